// File: rtl/dmem_pkg.sv
// RV32I data-memory shared definitions: funct3 codes, FSM states, lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dmem_state_e;

    // Byte-lane write strobe for a store; funct3[1:0] carries the access size.
    function automatic logic [3:0] strobe_gen(input logic [2:0] funct3,
                                              input logic [1:0] offset);
        logic [3:0] s;
        case (funct3[1:0])
            2'b00:   s = 4'b0001 << offset;
            2'b01:   s = offset[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Store data replicated on every lane so the strobe alone selects the bytes.
    function automatic logic [31:0] store_align(input logic [2:0]  funct3,
                                                input logic [31:0] wdata);
        logic [31:0] d;
        case (funct3[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Lane select plus sign/zero extension of a loaded word.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  offset,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = word;
            F3_BU:   r = {24'h0, b};
            F3_HU:   r = {16'h0, h};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the memory stage and the data memory.
// Latency: response one cycle after an accepted request.
// Backpressure: req_ready on the request side only; responses cannot stall.
// Signals: req_valid/req_ready handshake, req_we, req_addr, req_funct3,
//          req_wdata; rsp_valid, rsp_rdata, rsp_err.
interface dmem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct3;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write strobes.
// Latency: read data valid the cycle after re; a write is visible to a read on the next edge.
// Backpressure: none; accepts a read or write every cycle.
// Ports: i_clk, we/strb/idx/wdata write side, re/idx read side, rdata registered output.
module dmem_bank #(
    parameter int DEPTH_WORDS = 512,
    parameter int IDXW        = $clog2(DEPTH_WORDS)
) (
    input  logic            i_clk,
    input  logic            we,
    input  logic [3:0]      strb,
    input  logic            re,
    input  logic [IDXW-1:0] idx,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);
    logic [3:0][7:0] mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int l = 0; l < 4; l++) begin
                if (strb[l]) begin
                    mem[idx][l] <= wdata[8*l +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/dmem_lsu.sv
// RV32I data memory + load/store unit: strobe decode, load extend, error flagging.
// Latency: one cycle, request accept edge to response (rsp_valid pulses once per request).
// Backpressure: req_ready low during reset and the optional clear sweep; responses never stall.
// Ports: i_clk, i_rst_n (async active-low), bus (dmem_lsu_if.slave).
// Option: DMEM_CLEAR_ON_RESET_EN builds a post-reset sweep that zeroes every word.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int ADDR_W      = 32
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    dmem_lsu_if.slave bus
);
    localparam int IDXW = $clog2(DEPTH_WORDS);

    logic            req_ready;
    logic            accept;
    logic [IDXW-1:0] req_idx;
    logic [1:0]      req_off;
    logic [2:0]      req_f3;
    logic            f3_bad;
    logic            misalign;
    logic            out_of_range;
    logic            req_err;
    logic            do_store;

    logic            rsp_valid;
    logic            rsp_err;
    logic            rsp_load;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;

    logic            bank_we;
    logic            bank_re;
    logic [IDXW-1:0] bank_idx;
    logic [3:0]      bank_strb;
    logic [31:0]     bank_wdata;
    logic [31:0]     bank_rdata;

    assign accept  = bus.req_valid && req_ready;
    assign req_idx = bus.req_addr[IDXW+1:2];
    assign req_off = bus.req_addr[1:0];
    assign req_f3  = bus.req_funct3;

    // Stores only know B/H/W; loads reject 011, 110 and 111.
    assign f3_bad = bus.req_we ? (req_f3 > F3_W)
                               : ((req_f3 == 3'b011) || (req_f3[2:1] == 2'b11));
    assign misalign = ((req_f3[1:0] == 2'b01) && req_off[0])
                   || ((req_f3[1:0] == 2'b10) && (req_off != 2'b00));
    assign out_of_range = (bus.req_addr >> (IDXW + 2)) != '0;
    assign req_err      = f3_bad || misalign || out_of_range;

    assign do_store = accept && bus.req_we && !req_err;
    assign bank_re  = accept && !bus.req_we && !req_err;

`ifdef DMEM_CLEAR_ON_RESET_EN
    dmem_state_e     state;
    logic [IDXW-1:0] clr_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    // Counter holds at the last word; only reset restarts the sweep.
                    if (clr_cnt == IDXW'(DEPTH_WORDS - 1)) begin
                        state     <= RUN;
                        req_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                RUN: begin
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // The sweep owns the single RAM port while CLEAR; no request can be accepted then.
    assign bank_we    = (state == CLEAR) || do_store;
    assign bank_idx   = (state == CLEAR) ? clr_cnt : req_idx;
    assign bank_strb  = (state == CLEAR) ? 4'b1111 : strobe_gen(req_f3, req_off);
    assign bank_wdata = (state == CLEAR) ? 32'h0 : store_align(req_f3, bus.req_wdata);
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_ready <= 1'b0;
        end else begin
            req_ready <= 1'b1;
        end
    end

    assign bank_we    = do_store;
    assign bank_idx   = req_idx;
    assign bank_strb  = strobe_gen(req_f3, req_off);
    assign bank_wdata = store_align(req_f3, bus.req_wdata);
`endif

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDXW        (IDXW)
    ) u_bank (
        .i_clk (i_clk),
        .we    (bank_we),
        .strb  (bank_strb),
        .re    (bank_re),
        .idx   (bank_idx),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    // rsp_err/rsp_load are qualified by accept so they can never outlive rsp_valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_load  <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept && req_err;
            rsp_load  <= bank_re;
            if (accept) begin
                f3_q  <= req_f3;
                off_q <= req_off;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_err   = rsp_err;
    assign bus.rsp_rdata = rsp_load ? load_extend(f3_q, off_q, bank_rdata) : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed RV32I load/store cases, random traffic, resets.
// Latency: expects each accepted request to answer exactly one cycle later.
// Backpressure: issues only when req_ready is observed high; bounded waits on ready.
module tb_dmem_lsu;
    localparam int DEPTH = 512;
`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif
    localparam logic [32:0] NOFIX = 33'h0;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    dmem_lsu_if #(.ADDR_W(32)) bus ();

    dmem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    // Byte-addressed reference memory.
    logic [7:0] ref_mem [DEPTH*4];

    int          total = 0;
    int          bad   = 0;
    bit          pend  = 1'b0;
    logic [31:0] pend_rd;
    logic        pend_err;
    logic [32:0] pend_fix;
    string       pend_tag = "idle";

    function automatic logic [32:0] fx(input logic [31:0] v);
        return {1'b1, v};
    endfunction

    task automatic zero_model();
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
    endtask

    // RV32I access semantics over a flat byte array.
    task automatic model(input bit we, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd);
        int size;
        bit sgn;
        bit legal;
        logic [31:0] v;
        size = 4; sgn = 1'b0; legal = 1'b1;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: begin size = 1; legal = !we; end
            3'd5: begin size = 2; legal = !we; end
            default: legal = 1'b0;
        endcase
        err = !legal || ((int'(a[1:0]) % size) != 0) || (a >= 32'(DEPTH*4));
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < size; b++) ref_mem[int'(a) + b] = wd[8*b +: 8];
            end else begin
                v = 32'h0;
                for (int b = 0; b < size; b++) v = v | (32'(ref_mem[int'(a) + b]) << (8*b));
                if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                rd = v;
            end
        end
    endtask

    task automatic check_rsp();
        total++;
        assert (bus.rsp_valid === pend) else begin
            bad++; $error("FAIL %s rsp_valid got=%b exp=%b", pend_tag, bus.rsp_valid, pend);
        end
        if (pend) begin
            total++;
            assert (bus.rsp_rdata === pend_rd) else begin
                bad++; $error("FAIL %s rdata got=%h exp=%h", pend_tag, bus.rsp_rdata, pend_rd);
            end
            total++;
            assert (bus.rsp_err === pend_err) else begin
                bad++; $error("FAIL %s err got=%b exp=%b", pend_tag, bus.rsp_err, pend_err);
            end
            if (pend_fix[32]) begin
                total++;
                assert (bus.rsp_rdata === pend_fix[31:0]) else begin
                    bad++; $error("FAIL %s fixed rdata got=%h exp=%h", pend_tag, bus.rsp_rdata, pend_fix[31:0]);
                end
            end
        end
    endtask

    // One cycle: check the previous response, then present the next request.
    task automatic step(input bit v, input bit we, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, input logic [32:0] fix, input string tag);
        @(negedge i_clk);
        check_rsp();
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_addr   = a;
        bus.req_funct3 = f3;
        bus.req_wdata  = wd;
        pend     = v && (bus.req_ready === 1'b1);
        pend_fix = fix;
        pend_tag = tag;
        if (pend) model(we, a, f3, wd, pend_err, pend_rd);
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] f3, input logic [32:0] fix, input string tag);
        step(1'b1, 1'b0, a, f3, 32'h0, fix, tag);
    endtask

    task automatic st(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd, input string tag);
        step(1'b1, 1'b1, a, f3, wd, NOFIX, tag);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, NOFIX, "idle");
    endtask

    // Called on the negedge where reset is released.
    task automatic wait_ready(input int exp_cycles, input string tag);
        int n;
        bit spurious;
        n = 0;
        spurious = 1'b0;
        while (bus.req_ready !== 1'b1 && n < 3000) begin
            @(negedge i_clk);
            n++;
            if (bus.rsp_valid !== 1'b0) spurious = 1'b1;
        end
        total++;
        assert (n == exp_cycles) else begin
            bad++; $error("FAIL %s ready_delay got=%0d exp=%0d", tag, n, exp_cycles);
        end
        total++;
        assert (spurious == 1'b0) else begin
            bad++; $error("FAIL %s spurious_rsp_valid got=1 exp=0", tag);
        end
    endtask

    initial begin
        bit          rv;
        bit          rwe;
        logic [2:0]  rf3;
        logic [1:0]  roff;
        logic [31:0] ra;
        logic [31:0] rwd;

        i_rst_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_funct3 = 3'd0;
        bus.req_wdata  = 32'h0;
        zero_model();

        #12;
        total++; assert (bus.req_ready === 1'b0) else begin bad++; $error("FAIL rst_ready got=%b exp=0", bus.req_ready); end
        total++; assert (bus.rsp_valid === 1'b0) else begin bad++; $error("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
        total++; assert (bus.rsp_rdata === 32'h0) else begin bad++; $error("FAIL rst_rdata got=%h exp=0", bus.rsp_rdata); end
        total++; assert (bus.rsp_err === 1'b0) else begin bad++; $error("FAIL rst_err got=%b exp=0", bus.rsp_err); end

        @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_ready(CLR_EN ? DEPTH : 1, "release");

`ifndef DMEM_CLEAR_ON_RESET_EN
        // Contents are unspecified without the sweep: give every word a known value.
        for (int i = 0; i < DEPTH; i++) st(32'(i * 4), 3'd2, $urandom, "init");
`endif

`ifdef DMEM_CLEAR_ON_RESET_EN
        ld(32'h000, 3'd2, fx(32'h0), "lw_000_zero");
        ld(32'h7FC, 3'd2, fx(32'h0), "lw_7fc_zero");
`else
        ld(32'h000, 3'd2, NOFIX, "lw_000");
        ld(32'h7FC, 3'd2, NOFIX, "lw_7fc");
`endif
        st(32'h100, 3'd2, 32'hDEAD_BEEF, "sw_100");
        st(32'h101, 3'd0, 32'h0000_0055, "sb_101");
        ld(32'h100, 3'd2, fx(32'hDEAD_55EF), "lw_100");
        ld(32'h103, 3'd0, fx(32'hFFFF_FFDE), "lb_103");
        ld(32'h103, 3'd4, fx(32'h0000_00DE), "lbu_103");
        st(32'h202, 3'd1, 32'h0000_8001, "sh_202");
        ld(32'h202, 3'd1, fx(32'hFFFF_8001), "lh_202");
        ld(32'h202, 3'd5, fx(32'h0000_8001), "lhu_202");
        ld(32'h200, 3'd2, NOFIX, "lw_200_low_kept");
        ld(32'h102, 3'd2, fx(32'h0), "lw_misaligned");
        st(32'h203, 3'd1, 32'h0000_FFFF, "sh_misaligned");
        ld(32'h200, 3'd2, NOFIX, "lw_200_after_bad_sh");
        ld(32'h800, 3'd2, fx(32'h0), "lw_out_of_range");
        ld(32'h004, 3'd3, fx(32'h0), "ld_illegal_f3");
        st(32'h004, 3'd4, 32'hFFFF_FFFF, "st_illegal_f3");
        ld(32'h004, 3'd2, NOFIX, "lw_004_after_bad_st");
        st(32'h010, 3'd2, 32'h1234_5678, "sw_010");
        ld(32'h010, 3'd2, fx(32'h1234_5678), "lw_010_b2b");
        idle();

        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 4) != 0);
            rwe = ($urandom_range(0, 1) == 1);
            rf3 = 3'($urandom_range(0, 2));
            if (!rwe && $urandom_range(0, 2) == 0) rf3 = rf3 | 3'b100;
            if ($urandom_range(0, 15) == 0) rf3 = 3'($urandom_range(0, 7));
            roff = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (rf3[1:0] == 2'b10) roff = 2'b00;
                if (rf3[1:0] == 2'b01) roff[0] = 1'b0;
            end
            ra = 32'($urandom_range(0, 7)) * 4 + 32'(roff);
            if ($urandom_range(0, 1) == 1) ra = ra + 32'h7E0;
            if ($urandom_range(0, 15) == 0) ra = ra | (32'h1 << $urandom_range(11, 31));
            rwd = $urandom;
            step(rv, rwe, ra, rf3, rwd, NOFIX, "random");
        end
        idle();

        // Reset with a response in flight: it must vanish immediately.
        ld(32'h100, 3'd2, NOFIX, "pre_reset_load");
        @(posedge i_clk);
        #1;
        total++; assert (bus.rsp_valid === 1'b1) else begin bad++; $error("FAIL inflight_rsp got=%b exp=1", bus.rsp_valid); end
        i_rst_n = 1'b0;
        #1;
        total++; assert (bus.rsp_valid === 1'b0) else begin bad++; $error("FAIL rsp_dropped got=%b exp=0", bus.rsp_valid); end
        total++; assert (bus.req_ready === 1'b0) else begin bad++; $error("FAIL ready_in_reset got=%b exp=0", bus.req_ready); end
        total++; assert (bus.rsp_rdata === 32'h0) else begin bad++; $error("FAIL rdata_in_reset got=%h exp=0", bus.rsp_rdata); end
        pend = 1'b0;
        pend_tag = "after_reset";
        bus.req_valid = 1'b0;
        if (CLR_EN) zero_model();
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_ready(CLR_EN ? DEPTH : 1, "reset_midop");
        ld(32'h100, 3'd2, NOFIX, "lw_100_after_reset");
        ld(32'h010, 3'd2, NOFIX, "lw_010_after_reset");
        idle();

        // Reset again part-way through the sweep.
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (100) @(negedge i_clk);
`ifdef DMEM_CLEAR_ON_RESET_EN
        total++; assert (bus.req_ready === 1'b0) else begin bad++; $error("FAIL ready_mid_sweep got=%b exp=0", bus.req_ready); end
`endif
        i_rst_n = 1'b0;
        if (CLR_EN) zero_model();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_ready(CLR_EN ? DEPTH : 1, "reset_midsweep");
        ld(32'h100, 3'd2, NOFIX, "lw_100_after_sweep");
        ld(32'h7FC, 3'd0, NOFIX, "lb_7fc_after_sweep");
        ld(32'h202, 3'd5, NOFIX, "lhu_202_after_sweep");
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised RV32I data memory with an integrated load/store unit. It decodes funct3 and the byte address into lane strobes, aligns and extends load data, and flags misaligned, out-of-range or illegal accesses. Storage uses a synchronous-read, byte-lane RAM behind a valid/ready request port. An optional post-reset sweep zeroes every word. The block sits on the core's memory stage in place of a raw word array.

## Interface
- DEPTH_WORDS, 512, number of 32-bit words; power of two, >= 4
- ADDR_W, 32, byte-address width; must be >= $clog2(DEPTH_WORDS)+2
- i_clk  in  1  clock; all state changes on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  block can accept a request this cycle
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  ADDR_W  byte address
- i_req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- i_req_wdata  in  32  unshifted store data (rs2)
- o_rsp_valid  out  1  response for the request accepted in the previous cycle
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors
- o_rsp_err  out  1  access rejected: misaligned, out of range or illegal funct3

## Operation
- Acceptance: a request is accepted on a rising edge where i_req_valid && o_req_ready. Throughput is one request per cycle. Responses have no backpressure.
- Decode: word index = addr[IDXW+1:2], where IDXW = $clog2(DEPTH_WORDS). Byte offset = addr[1:0].
- Error conditions; any one of them sets o_rsp_err:
  - halfword access with addr[0]=1
  - word access with addr[1:0]≠0
  - any of addr[ADDR_W-1:IDXW+2] nonzero
  - load funct3 in {011,110,111}
  - store funct3 > 010
- On error: no array write, o_rsp_rdata=0, o_rsp_err=1.
- Store lane strobes:
  - SB: strobe bit [offset] set, byte replicated on all lanes
  - SH: 0011 (offset 0) or 1100 (offset 2), halfword replicated
  - SW: 1111
- Unstrobed bytes are never modified. A store response carries rdata=0, err=0.
- Load: the addressed word is read synchronously. Offset and funct3 are registered at accept. The lane is selected next cycle:
  - LB/LH: sign-extend
  - LBU/LHU: zero-extend
  - LW: word unchanged
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated bytes. The store commits at its accept edge, before the load's read edge.
- FSM, states CLEAR and RUN:
  - Reset forces CLEAR (macro on) or RUN (macro off).
  - CLEAR writes 0 to word clr_cnt each cycle with o_req_ready=0.
  - At clr_cnt==DEPTH_WORDS-1, CLEAR → RUN.
  - RUN has no exit except reset.

## Timing
- Reset values: o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, clr_cnt=0. These apply asynchronously while i_rst_n=0.
- Load/store latency: response on the edge after accept, i.e. o_rsp_valid high for exactly one cycle per accepted request.
- o_req_ready is a registered state decode: high in RUN, low in CLEAR and reset.
- Macro on: the first accept is possible on edge DEPTH_WORDS+1 after reset release. Edges 1..DEPTH_WORDS perform the sweep.
- Macro off: o_req_ready rises after the first edge after release; the first accept is possible on edge 2.
- Reset mid-operation: the in-flight response is dropped (o_rsp_valid→0 immediately). The sweep restarts from word 0. Array contents are preserved when the macro is off.
- clr_cnt wraps only through reset; it never exceeds DEPTH_WORDS-1.

## Configuration
- DMEM_CLEAR_ON_RESET_EN:
  - Defined: CLEAR state and clr_cnt are built, and every reset zeroes the whole array.
  - Undefined: CLEAR and clr_cnt are removed; array contents after power-up are unspecified and survive reset.

## Structure
- Package dmem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum dmem_state_e {CLEAR, RUN}
  - function strobe_gen(funct3, offset) returning 4-bit strobe
  - function load_extend(funct3, offset, word) returning 32-bit result
- One sub-module, dmem_bank: DEPTH_WORDS×32 synchronous-read RAM with 4-bit byte-write strobe, single port, write-before-read-next-cycle semantics. Contains no reset logic.

## Test plan
- Macro on, reset release: ready low for 512 cycles, then LW 0x000 and LW 0x7FC → rdata 0x00000000, err 0.
- SW 0x100 ← 0xDEADBEEF, then SB 0x101 ← 0x55 → LW 0x100 = 0xDEAD55EF. LB 0x103 = 0xFFFFFFDE. LBU 0x103 = 0x000000DE.
- SH 0x202 ← 0x8001 → LH 0x202 = 0xFFFF8001, LHU 0x202 = 0x00008001, word 0x200 low half unchanged.
- Misaligned and range errors: LW 0x102 → err 1, rdata 0. SH 0x203 → err 1, memory unchanged. LW 0x800 (DEPTH 512) → err 1.
- Back-to-back traffic: SW 0x10 ← 0x12345678 then LW 0x10 on the next cycle → response 0x12345678 one cycle after the load is accepted, with no bubble.
- Reset asserted mid-sweep at count 100, released → sweep restarts at 0, ready rises after 512 cycles, no spurious o_rsp_valid.
